// File: rtl/ps2_kbd_rx_fifo.sv
// PS/2 keyboard receiver: oversampled kclk/kdata, frame validation, E0/F0 prefix decode,
// and a show-ahead event FIFO drained by the CPU through keyboard_cs/rd.
`timescale 1ns/1ps
module ps2_kbd_rx_fifo #(
    parameter int FIFO_DEPTH  = 8,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          kclk,
    input  logic                          kdata,
    input  logic                          keyboard_cs,
    input  logic                          rd,
    input  logic                          clr,
    output logic [7:0]                    kb_data,
    output logic                          kb_break,
    output logic                          kb_ext,
    output logic                          kb_ready,
    output logic [$clog2(FIFO_DEPTH):0]   kb_count,
    output logic                          kb_overflow,
    output logic                          kb_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYC);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CHECK} state_t;

    state_t          r_state, w_state_nxt;
    logic            r_kclk_s1, r_kclk_s2, r_kdata_s1, r_kdata_s2;
    logic            r_kclk_f, r_kclk_f_d;
    logic [FW-1:0]   r_filt_cnt;
    logic [TW-1:0]   r_to_cnt;
    logic [3:0]      r_bit_cnt;
    logic [9:0]      r_shift;
    logic            r_ext_p, r_brk_p;
    logic [9:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [AW:0]     r_count;
    logic            r_overflow, r_err;

    logic            w_fall, w_timeout, w_frame_ok, w_frame_bad;
    logic            w_push, w_pop, w_full, w_wr, w_drop;
    logic [7:0]      w_byte;
    logic [9:0]      w_head;

    // Stage: synchronisers and glitch filter on kclk
    always_ff @(posedge clk) begin
        if (rst) begin
            r_kclk_s1  <= 1'b1;
            r_kclk_s2  <= 1'b1;
            r_kdata_s1 <= 1'b1;
            r_kdata_s2 <= 1'b1;
            r_kclk_f   <= 1'b1;
            r_kclk_f_d <= 1'b1;
            r_filt_cnt <= '0;
        end else begin
            r_kclk_s1  <= kclk;
            r_kclk_s2  <= r_kclk_s1;
            r_kdata_s1 <= kdata;
            r_kdata_s2 <= r_kdata_s1;
            r_kclk_f_d <= r_kclk_f;
            if (r_kclk_s2 != r_kclk_f) begin
                if (r_filt_cnt == FILT_MAX) begin
                    r_kclk_f   <= r_kclk_s2;
                    r_filt_cnt <= '0;
                end else begin
                    r_filt_cnt <= r_filt_cnt + 1'b1;
                end
            end else begin
                r_filt_cnt <= '0;
            end
        end
    end

    assign w_fall      = r_kclk_f_d & ~r_kclk_f;
    assign w_byte      = r_shift[7:0];
    assign w_frame_ok  = (^r_shift[8:0]) & r_shift[9];
    assign w_frame_bad = (r_state == S_CHECK) & ~w_frame_ok;

    // Stage: receive FSM
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE:  if (w_fall && !r_kdata_s2) w_state_nxt = S_SHIFT;
            S_SHIFT: begin
                if (w_fall) begin
                    if (r_bit_cnt == 4'd10) w_state_nxt = S_CHECK;
                end else if (r_to_cnt == TO_MAX) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_CHECK: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt <= '0;
            r_to_cnt  <= '0;
            r_ext_p   <= 1'b0;
            r_brk_p   <= 1'b0;
        end else begin
            if (r_state != S_SHIFT || w_fall || w_timeout) r_to_cnt <= '0;
            else                                           r_to_cnt <= r_to_cnt + 1'b1;
            case (r_state)
                S_IDLE:  if (w_fall && !r_kdata_s2) r_bit_cnt <= 4'd1;
                S_SHIFT: begin
                    if (w_fall)         r_bit_cnt <= r_bit_cnt + 4'd1;
                    else if (w_timeout) r_bit_cnt <= '0;
                end
                S_CHECK: begin
                    r_bit_cnt <= '0;
                    // Bad frames drop any pending prefix so it cannot attach to a later code.
                    if (w_frame_ok && w_byte == 8'hE0)      r_ext_p <= 1'b1;
                    else if (w_frame_ok && w_byte == 8'hF0) r_brk_p <= 1'b1;
                    else begin
                        r_ext_p <= 1'b0;
                        r_brk_p <= 1'b0;
                    end
                end
                default: r_bit_cnt <= '0;
            endcase
        end
    end

    // Bits 1..10 enter at the top, so after the stop bit [7:0]=data, [8]=parity, [9]=stop.
    always_ff @(posedge clk) begin
        if (r_state == S_SHIFT && w_fall) r_shift <= {r_kdata_s2, r_shift[9:1]};
    end

    // Stage: event FIFO and sticky flags
    assign w_push = (r_state == S_CHECK) & w_frame_ok & (w_byte != 8'hE0) & (w_byte != 8'hF0);
    assign w_pop  = keyboard_cs & rd & (r_count != '0);
    assign w_full = (r_count == FULL_CNT);
    assign w_wr   = w_push & (~w_full | w_pop);
    assign w_drop = w_push & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= {r_ext_p, r_brk_p, w_byte};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop)                   r_overflow <= 1'b1;
            else if (keyboard_cs && clr)  r_overflow <= 1'b0;
            if (w_frame_bad || w_timeout) r_err <= 1'b1;
            else if (keyboard_cs && clr)  r_err <= 1'b0;
        end
    end

    assign w_head      = r_mem[r_rd_ptr];
    assign kb_ready    = (r_count != '0);
    assign kb_data     = kb_ready ? w_head[7:0] : 8'h00;
    assign kb_break    = kb_ready & w_head[8];
    assign kb_ext      = kb_ready & w_head[9];
    assign kb_count    = r_count;
    assign kb_overflow = r_overflow;
    assign kb_err      = r_err;

endmodule

// File: doc/ps2_kbd_rx_fifo.md
Name: ps2_kbd_rx_fifo

Overview:
PS/2 keyboard receiver for the MIPS SoC peripheral bus. It runs entirely in the system clock domain and oversamples kclk/kdata. It validates each 11-bit frame (start, parity, stop) and decodes the E0 (extended) and F0 (break) prefixes. Decoded key events go into a show-ahead FIFO that the CPU drains through a chip-select/read strobe, replacing the previous single-byte, kclk-clocked, break-only receiver.

Parameters:
FIFO_DEPTH, 8, number of key-event entries; power of two, 2..64.
FILTER_LEN, 4, consecutive identical clk samples required to accept a new kclk level (glitch filter).
TIMEOUT_CYC, 50000, clk cycles without a kclk falling edge before a partial frame is discarded.

Ports:
clk  input  1  system clock; the only clock.
rst  input  1  synchronous, active-high reset.
kclk  input  1  PS/2 clock pin, asynchronous.
kdata  input  1  PS/2 data pin, asynchronous.
keyboard_cs  input  1  peripheral chip select.
rd  input  1  pop strobe; acts only when keyboard_cs=1.
clr  input  1  clears the sticky error flags; acts only when keyboard_cs=1.
kb_data  output  8  scan code at the FIFO head.
kb_break  output  1  head entry is a key release.
kb_ext  output  1  head entry had the E0 prefix.
kb_ready  output  1  FIFO non-empty.
kb_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
kb_overflow  output  1  sticky: an event was dropped because the FIFO was full.
kb_err  output  1  sticky: a frame error or timeout occurred.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): all outputs 0, FIFO empty, bit counter 0, prefix flags clear, filtered kclk=1, timeout counter 0.
- Synchronisers: kclk and kdata each pass through 2 flops.
- Glitch filter: the filtered kclk changes only after FILTER_LEN consecutive equal samples.
- Edge detection: fall_pulse is a 1-cycle pulse when filtered kclk goes 1->0. kdata (synchronised) is sampled on that cycle.
- Receive FSM states: IDLE, SHIFT, CHECK.
  - IDLE: on fall_pulse with kdata=0 (start bit), go to SHIFT with bit_cnt=1. A start bit of 1 is ignored and the FSM stays in IDLE with no error.
  - SHIFT: each fall_pulse stores one bit; bits 1-8 are data LSB-first, bit 9 is odd parity, bit 10 is stop. After bit 10 is stored, go to CHECK.
  - CHECK (1 cycle): the frame is valid iff ^data^parity==1 and stop==1. On an invalid frame, set kb_err, clear both prefix flags and push nothing. Always return to IDLE.
- Timeout: in SHIFT, a counter increments each cycle and clears on fall_pulse. When it reaches TIMEOUT_CYC, set kb_err, go to IDLE with bit_cnt=0, and leave the prefix flags unchanged.
- Prefix decode (valid bytes only):
  - 0xE0 sets ext_p.
  - 0xF0 sets brk_p.
  - Any other byte pushes {ext_p, brk_p, byte} and clears both flags. This includes 0xE1, 0xFA and 0xAA, which are pushed as plain codes.
  - A repeated prefix (e.g. E0 E0) simply keeps the flag set.
- Latency: the push happens on the clk edge that ends CHECK. kb_ready/kb_data reflect the new entry in the next cycle when the FIFO was empty.
- FIFO is show-ahead: kb_data/kb_break/kb_ext always show the head entry, and are 0 when empty.
- Pop: happens on a clk edge with keyboard_cs&rd and not empty. The next entry (or zeros) is visible the following cycle. A pop when empty is ignored and does not flag an error.
- Full: a push when kb_count==FIFO_DEPTH is dropped and sets kb_overflow, unless a pop occurs in the same cycle. Push and pop in the same cycle are both performed, and kb_count is unchanged.
- Pointers wrap modulo FIFO_DEPTH; kb_count saturates at FIFO_DEPTH.
- Sticky flags: cleared by keyboard_cs&clr. If a set and a clear happen in the same cycle, set wins.
- Reset asserted mid-frame: the partial frame is discarded with no error, and the FIFO is emptied.

Test Plan:
- Frame 0x1C at ~12.5 kHz kclk -> one entry kb_data=0x1C, kb_break=0, kb_ext=0, kb_ready=1, kb_count=1; rd pop -> kb_ready=0, kb_data=0x00.
- Sequence F0 1C, then E0 75, then E0 F0 75 -> three entries in order {00,1,1C}, {1,0,75}, {1,1,75}; the prefix bytes are never visible as entries.
- Frame 0x1C with parity bit inverted -> no entry, kb_err=1; a following valid 0x32 -> entry {0,0,32}; clr -> kb_err=0.
- Stop after 5 bits of a frame with no further edges for TIMEOUT_CYC (use 200 in test) -> kb_err=1, FSM back in IDLE; the next full frame 0x1C is received correctly.
- FIFO_DEPTH=4: send 5 codes 0x15,0x1D,0x24,0x2D,0x2C with no reads -> kb_count=4, kb_overflow=1, pops yield 15,1D,24,2D; repeat the 5th code while rd is held on its push cycle -> accepted, kb_count stays 4.
- kclk low glitch of FILTER_LEN-1 cycles in IDLE and mid-frame -> no bit is taken, and received data is unaffected.
